// File: rtl/ccff_loader_pkg.sv
// Shared types and defaults for the configuration-chain bitstream loader.
// Holds the FSM state enum, the default geometry and a bit-index width helper.
package ccff_loader_pkg;

  localparam int unsigned DEF_WORD_W    = 8;
  localparam int unsigned DEF_CHAIN_LEN = 58;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } ccff_state_e;

  // A one-bit word still needs a one-bit index signal.
  function automatic int unsigned idx_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/ccff_bitstream_loader_if.sv
// Host-side word handshake into the bitstream loader (valid/ready, MSB-first words).
interface ccff_bitstream_loader_if
  import ccff_loader_pkg::*;
#(
  parameter int unsigned WORD_W = DEF_WORD_W
) ();

  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;

  modport master (
    output cfg_data,
    output cfg_valid,
    input  cfg_ready
  );

  modport slave (
    input  cfg_data,
    input  cfg_valid,
    output cfg_ready
  );

endinterface

// File: rtl/ccff_piso_shreg.sv
// Word shift register: parallel load, MSB-first left shift with serial fill, bit index
// and last-bit flag. Serves both as the transmit PISO and the readback SIPO.
module ccff_piso_shreg
  import ccff_loader_pkg::*;
#(
  parameter  int unsigned W  = DEF_WORD_W,
  localparam int unsigned IW = idx_width(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [W-1:0]  load_data,
  input  logic          shift,
  input  logic          ser_in,
  output logic [W-1:0]  q,
  output logic [W-1:0]  q_next,
  output logic          ser_out,
  output logic [IW-1:0] bit_idx,
  output logic          last_bit
);

  if (W == 1) begin : g_one
    assign q_next = ser_in;
  end else begin : g_multi
    assign q_next = {q[W-2:0], ser_in};
  end

  // Shifting left keeps the original bit at bit_idx parked in the MSB.
  assign ser_out  = q[W-1];
  assign last_bit = (bit_idx == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= '0;
      bit_idx <= '0;
    end else if (load) begin
      q       <= load_data;
      bit_idx <= IW'(W - 1);
    end else if (shift) begin
      q       <= q_next;
      bit_idx <= last_bit ? IW'(W - 1) : bit_idx - 1'b1;
    end
  end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Serialises host words onto ccff_head with a per-bit clock enable, exactly CHAIN_LEN bits per load.
// Optional CCFF_READBACK_EN captures ccff_tail into rb_data/rb_valid words.
//
// state | meaning
// IDLE  | no load since reset; waiting for cfg_start
// FETCH | busy, cfg_ready high, waiting for a host word
// SHIFT | one chain bit per cycle on ccff_head, ccff_clk_en high
// DONE  | chain fully loaded, cfg_done high until next cfg_start
module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter  int unsigned WORD_W    = DEF_WORD_W,
  parameter  int unsigned CHAIN_LEN = DEF_CHAIN_LEN,
  localparam int unsigned CNT_W     = $clog2(CHAIN_LEN + 1),
  localparam int unsigned IDX_W     = idx_width(WORD_W)
) (
  input  logic                  prog_clk,
  input  logic                  pReset,
  input  logic                  cfg_start,
  ccff_bitstream_loader_if.slave host,
  output logic                  ccff_head,
  output logic                  ccff_clk_en,
  input  logic                  ccff_tail,
  output logic                  cfg_busy,
`ifdef CCFF_READBACK_EN
  output logic                  cfg_done,
  output logic [WORD_W-1:0]     rb_data,
  output logic                  rb_valid
`else
  output logic                  cfg_done
`endif
);

  ccff_state_e      state, state_d;
  logic [CNT_W-1:0] bits_left, bits_left_d;
  logic             cfg_ready_c;
  logic             start_ok;
  logic             final_bit;

  logic              tx_load, tx_shift, tx_last, tx_ser;
  logic [WORD_W-1:0] tx_q_unused, tx_next_unused;
  logic [IDX_W-1:0]  tx_idx_unused;

  assign start_ok  = cfg_start && ((state == IDLE) || (state == DONE));
  assign final_bit = (state == SHIFT) && (bits_left == CNT_W'(1));

  assign host.cfg_ready = cfg_ready_c;

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state     <= IDLE;
      bits_left <= '0;
    end else begin
      state     <= state_d;
      bits_left <= bits_left_d;
    end
  end

  always_comb begin
    state_d     = state;
    bits_left_d = bits_left;
    cfg_ready_c = 1'b0;
    ccff_head   = 1'b0;
    ccff_clk_en = 1'b0;
    cfg_busy    = 1'b0;
    cfg_done    = 1'b0;
    tx_load     = 1'b0;
    tx_shift    = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_d     = FETCH;
          bits_left_d = CNT_W'(CHAIN_LEN);
        end
      end
      DONE: begin
        cfg_done = 1'b1;
        if (start_ok) begin
          state_d     = FETCH;
          bits_left_d = CNT_W'(CHAIN_LEN);
        end
      end
      FETCH: begin
        cfg_busy    = 1'b1;
        cfg_ready_c = 1'b1;
        if (host.cfg_valid) begin
          tx_load = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        cfg_busy    = 1'b1;
        ccff_clk_en = 1'b1;
        ccff_head   = tx_ser;
        tx_shift    = 1'b1;
        bits_left_d = bits_left - 1'b1;
        if (final_bit) begin
          // Any unsent low bits of a partial last word are simply dropped.
          state_d = DONE;
        end else if (tx_last) begin
          cfg_ready_c = 1'b1;
          if (host.cfg_valid) begin
            tx_load = 1'b1;
          end else begin
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  ccff_piso_shreg #(.W(WORD_W)) u_tx (
    .clk       (prog_clk),
    .rst       (pReset),
    .load      (tx_load),
    .load_data (host.cfg_data),
    .shift     (tx_shift),
    .ser_in    (1'b0),
    .q         (tx_q_unused),
    .q_next    (tx_next_unused),
    .ser_out   (tx_ser),
    .bit_idx   (tx_idx_unused),
    .last_bit  (tx_last)
  );

`ifdef CCFF_READBACK_EN
  logic [WORD_W-1:0] rb_q_unused, rb_next;
  logic [IDX_W-1:0]  rb_idx;
  logic              rb_last, rb_ser_unused;

  // Cleared on each accepted start so capture words line up with the load.
  ccff_piso_shreg #(.W(WORD_W)) u_rb (
    .clk       (prog_clk),
    .rst       (pReset),
    .load      (start_ok),
    .load_data ({WORD_W{1'b0}}),
    .shift     (ccff_clk_en),
    .ser_in    (ccff_tail),
    .q         (rb_q_unused),
    .q_next    (rb_next),
    .ser_out   (rb_ser_unused),
    .bit_idx   (rb_idx),
    .last_bit  (rb_last)
  );

  // Shifting by the remaining index left-aligns a partial final word and zero-pads it.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      rb_valid <= 1'b0;
      rb_data  <= '0;
    end else begin
      rb_valid <= 1'b0;
      if (ccff_clk_en && (rb_last || final_bit)) begin
        rb_valid <= 1'b1;
        rb_data  <= rb_next << rb_idx;
      end
    end
  end
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Directed bench for ccff_bitstream_loader: table of load scenarios plus reset/ignore/readback sequences.
module tb_ccff_bitstream_loader;
  import ccff_loader_pkg::*;

  localparam int W  = 8;
  localparam int L  = 58;
  localparam int NW = (L + W - 1) / W;
  localparam int K_LAST = L - (NW - 1) * W;

  logic prog_clk = 1'b0;
  logic pReset   = 1'b1;
  logic cfg_start = 1'b0;
  logic ccff_tail;
  logic ccff_head, ccff_clk_en, cfg_busy, cfg_done;
`ifdef CCFF_READBACK_EN
  logic [W-1:0] rb_data;
  logic         rb_valid;
`endif

  ccff_bitstream_loader_if #(.WORD_W(W)) host ();

  ccff_bitstream_loader #(.WORD_W(W), .CHAIN_LEN(L)) dut (
    .prog_clk    (prog_clk),
    .pReset      (pReset),
    .cfg_start   (cfg_start),
    .host        (host.slave),
    .ccff_head   (ccff_head),
    .ccff_clk_en (ccff_clk_en),
    .ccff_tail   (ccff_tail),
    .cfg_busy    (cfg_busy),
`ifdef CCFF_READBACK_EN
    .cfg_done    (cfg_done),
    .rb_data     (rb_data),
    .rb_valid    (rb_valid)
`else
    .cfg_done    (cfg_done)
`endif
  );

  always #5 prog_clk = ~prog_clk;

  // Downstream chain model: shifts on gated clock, tail is the oldest bit.
  logic [L-1:0] chain = '0;
  always @(posedge prog_clk) if (ccff_clk_en) chain <= {chain[L-2:0], ccff_head};
  assign ccff_tail = chain[L-1];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor, sampled on the falling edge.
  int   cyc = 0, cap_n = 0, gaps = 0, last_bit_cyc = 0, done_cyc = -1;
  bit   seen = 1'b0;
  logic cap_bits [0:127];
  logic ready_at_final = 1'b0;
  logic [W-1:0] rb_words [0:15];
  int   rb_n = 0;

  always @(negedge prog_clk) begin
    cyc++;
    if (ccff_clk_en) begin
      if (cap_n < 128) cap_bits[cap_n] = ccff_head;
      cap_n++;
      seen = 1'b1;
      last_bit_cyc = cyc;
      if (cap_n == L) ready_at_final = host.cfg_ready;
    end else if (seen && cfg_busy) begin
      gaps++;
    end
    if (cfg_done && seen && done_cyc < 0) done_cyc = cyc;
`ifdef CCFF_READBACK_EN
    if (rb_valid) begin
      if (rb_n < 16) rb_words[rb_n] = rb_data;
      rb_n++;
    end
`endif
  end

  task automatic clear_monitor();
    cap_n = 0; gaps = 0; seen = 1'b0; done_cyc = -1; last_bit_cyc = 0;
    ready_at_final = 1'b0; rb_n = 0;
  endtask

  typedef struct {
    logic [63:0] bits;
    int          stall_word;
    int          stall_len;
    int          start_word;
    bit          final_start;
    int          exp_gaps;
  } vec_t;

  vec_t vecs [4];

  task automatic run_vec(input vec_t v, input string tag);
    int t;
    int bad;
    int ready_in_done;
    clear_monitor();
    @(posedge prog_clk); #1;
    cfg_start = 1'b1;
    host.cfg_valid = 1'b1;
    host.cfg_data  = v.bits[63 -: W];
    @(posedge prog_clk); #1;
    cfg_start = 1'b0;
    for (int w = 0; w < NW; w++) begin
      host.cfg_valid = 1'b1;
      host.cfg_data  = v.bits[63 - w*W -: W];
      t = 0;
      do begin @(negedge prog_clk); t++; end while (!host.cfg_ready && t < 200);
      if (t >= 200) begin
        check({tag, " handshake timeout"}, w, -1);
        break;
      end
      @(posedge prog_clk); #1;
      if (w == NW - 1) begin
        host.cfg_valid = 1'b0;
        if (v.final_start) begin
          repeat (K_LAST - 1) @(posedge prog_clk);
          #1 cfg_start = 1'b1;
          @(posedge prog_clk); #1 cfg_start = 1'b0;
        end
      end else if (w == v.stall_word) begin
        host.cfg_valid = 1'b0;
        t = 0;
        do begin @(negedge prog_clk); t++; end while (ccff_clk_en && t < 200);
        repeat (v.stall_len - 1) @(negedge prog_clk);
        @(posedge prog_clk); #1;
      end else if (w == v.start_word) begin
        cfg_start = 1'b1;
        @(posedge prog_clk); #1 cfg_start = 1'b0;
      end
    end
    t = 0;
    while (!cfg_done && t < 200) begin @(negedge prog_clk); t++; end
    check({tag, " done timeout"}, (t < 200) ? 1 : 0, 1);
    host.cfg_valid = 1'b1;
    ready_in_done = 0;
    repeat (3) begin @(negedge prog_clk); if (host.cfg_ready) ready_in_done++; end
    host.cfg_valid = 1'b0;
    bad = -1;
    for (int k = L - 1; k >= 0; k--) if (cap_bits[k] !== v.bits[63 - k]) bad = k;
    check({tag, " bit count"}, cap_n, L);
    check({tag, " first bad bit index"}, bad, -1);
    check({tag, " gap cycles"}, gaps, v.exp_gaps);
    check({tag, " done latency"}, done_cyc - last_bit_cyc, 1);
    check({tag, " ready on final bit"}, ready_at_final, 0);
    check({tag, " ready in DONE"}, ready_in_done, 0);
    check({tag, " done level held"}, cfg_done, 1);
    check({tag, " busy after done"}, cfg_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt, bad_cnt;
    vecs[0] = '{64'hA53C_FF00_9669_12C0, -1, 0, -1, 1'b1, 0};
    vecs[1] = '{64'h0123_4567_89AB_CDEF, -1, 0, -1, 1'b0, 0};
    vecs[2] = '{64'hDEAD_BEEF_CAFE_F00D,  3, 5, -1, 1'b0, 6};
    vecs[3] = '{64'hFFFF_0000_FFFF_0000, -1, 0,  2, 1'b0, 0};

    host.cfg_valid = 1'b0;
    host.cfg_data  = '0;
    repeat (3) @(posedge prog_clk);
    @(negedge prog_clk);
    check("reset ready", host.cfg_ready, 0);
    check("reset head", ccff_head, 0);
    check("reset clk_en", ccff_clk_en, 0);
    check("reset busy", cfg_busy, 0);
    check("reset done", cfg_done, 0);

    // Valid while idle must be ignored.
    @(posedge prog_clk); #1;
    pReset = 1'b0;
    host.cfg_valid = 1'b1;
    host.cfg_data  = 8'hFF;
    bad_cnt = 0;
    repeat (4) begin
      @(negedge prog_clk);
      if (host.cfg_ready || cfg_busy || ccff_clk_en) bad_cnt++;
    end
    check("idle valid ignored", bad_cnt, 0);
    host.cfg_valid = 1'b0;

    for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Abort after 20 bits, then a clean reload.
    @(posedge prog_clk); #1;
    cfg_start = 1'b1;
    host.cfg_valid = 1'b1;
    host.cfg_data  = 8'hFF;
    @(posedge prog_clk); #1;
    cfg_start = 1'b0;
    cnt = 0;
    for (int t = 0; t < 200 && cnt < 20; t++) begin
      @(negedge prog_clk);
      if (ccff_clk_en) cnt++;
    end
    check("abort bits seen", cnt, 20);
    pReset = 1'b1;
    @(negedge prog_clk);
    check("abort outputs", {host.cfg_ready, ccff_head, ccff_clk_en, cfg_busy, cfg_done}, 0);
    @(posedge prog_clk); #1;
    pReset = 1'b0;
    host.cfg_valid = 1'b0;
    @(negedge prog_clk);
    check("abort stays idle", {cfg_busy, cfg_done}, 0);
    run_vec(vecs[1], "reload");

`ifdef CCFF_READBACK_EN
    chain = 58'h2AA_AAAA_AAAA_AAAA;
    run_vec(vecs[3], "readback");
    check("rb pulse count", rb_n, 8);
    for (int i = 0; i < 7; i++) check($sformatf("rb word %0d", i), rb_words[i], 8'hAA);
    check("rb partial word", rb_words[7], 8'h80);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
